pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
Centralised pipeline control unit for the five-stage Y86-64 pipe. It takes hazard-relevant fields from the D, E, M and W stage registers and the e/m stage results. Each cycle it drives the stall/bubble controls for the F, D, E, M and W stage registers and gates condition-code updates. It also owns the processor run/halt state machine, the latched exception code and the saturating performance counters.

Parameters:
CNT_W, 32, width of each performance counter
IC_NOP, 4'h1, icode injected by a bubble; never counted as retired

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
D_icode  input  4  icode in D register
d_srcA  input  4  decode source A (4'hF = none)
d_srcB  input  4  decode source B (4'hF = none)
E_icode  input  4  icode in E register
E_dstM  input  4  E-stage memory destination (4'hF = none)
e_cnd  input  1  branch/cmov condition from execute
M_icode  input  4  icode in M register
m_stat  input  2  status out of memory stage (0 AOK, 1 HLT, 2 ADR, 3 INS)
W_icode  input  4  icode in W register
W_stat  input  2  status in W register
F_stall  output  1  hold F (predPC)
D_stall  output  1  hold D
D_bubble  output  1  load nop into D
E_bubble  output  1  load nop into E
M_bubble  output  1  load nop into M
W_stall  output  1  hold W
set_cc_en  output  1  permit CC write from execute
halted  output  1  processor stopped (registered)
exc_code  output  2  status that caused the halt (registered)
cyc_cnt  output  CNT_W  cycles spent in RUN
ret_cnt  output  CNT_W  retired instructions
lu_cnt  output  CNT_W  load/use stall cycles
mp_cnt  output  CNT_W  mispredict flush cycles

Behaviour:
- Hazard terms, all combinational:
  - lu = (E_icode==5 or E_icode==B) and E_dstM!=F and (E_dstM==d_srcA or E_dstM==d_srcB).
  - mp = E_icode==7 and e_cnd==0.
  - rt = D_icode==9 or E_icode==9 or M_icode==9.
  - exM = m_stat!=0.
  - exW = W_stat!=0.
- RUN outputs:
  - F_stall = lu or rt.
  - D_stall = lu.
  - D_bubble = mp or (rt and not lu). Load/use wins over ret.
  - E_bubble = mp or lu.
  - M_bubble = exM or exW.
  - W_stall = exW.
  - set_cc_en = not exM and not exW.
- Invariant: D_stall and D_bubble are never both 1.
- FSM states: RUN, HALT.
  - RUN -> HALT on a posedge where exW=1. On that edge, latch exc_code <= W_stat and set halted <= 1.
  - HALT is absorbing; only rst leaves it.
- HALT outputs:
  - F_stall=1, D_stall=1, W_stall=1.
  - D_bubble=0, E_bubble=1, M_bubble=1.
  - set_cc_en=0.
  - Hazard inputs are ignored.
- rst high (takes priority in any state):
  - Next state RUN; halted=0; exc_code=0; all counters=0.
  - Same-cycle outputs: F_stall=0, D_stall=0, W_stall=0, D_bubble=1, E_bubble=1, M_bubble=1, set_cc_en=0. This flushes the stage registers.
  - rst asserted mid-HALT or mid-stall behaves identically.
- Counters update on posedge, in RUN only (not during rst, not in HALT). Each saturates at 2^CNT_W-1 with no wrap.
  - cyc_cnt: +1 every RUN cycle.
  - ret_cnt: +1 when W_icode!=IC_NOP and W_stat==0 and W_stall==0.
  - lu_cnt: +1 when lu.
  - mp_cnt: +1 when mp.
  - lu and mp in the same cycle increment both counters.
- Latency: stage controls are zero-cycle (combinational from inputs). halted and exc_code become visible one cycle after exW is first sampled.
- A HLT instruction reaching W (W_stat=1) halts with exc_code=1, the same path as ADR/INS.

Test Plan:
- mrmovq to %rax in E (E_icode=5, E_dstM=0) with d_srcA=0 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt +1; next cycle with E_icode=1 all controls deasserted.
- jXX mispredict (E_icode=7, e_cnd=0) -> D_bubble=1, E_bubble=1, F_stall=0; mp_cnt +1.
- ret walking D->E->M over 3 cycles -> F_stall=1 and D_bubble=1 on each cycle; 4th cycle clear. Ret in D combined with load/use in E -> D_stall=1, D_bubble=0, E_bubble=1.
- m_stat=2 with E_icode=6 -> M_bubble=1, set_cc_en=0. Next cycle W_stat=2 -> W_stall=1. Following cycle halted=1, exc_code=2, all counters frozen over 10 further cycles.
- Assert rst while halted -> same-cycle D/E/M_bubble=1, stalls 0. After the edge, halted=0 and counters 0; 5 idle RUN cycles give cyc_cnt=5.
- CNT_W=4, 20 RUN cycles -> cyc_cnt holds at 15, no wrap.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : Y86-64 five-stage pipeline control: hazard stall/bubble, run/halt
//            state, latched exception code and saturating perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_unit #(
    parameter int         CNT_W  = 32,
    parameter logic [3:0] IC_NOP = 4'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc_en,
    output logic             halted,
    output logic [1:0]       exc_code,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    localparam logic [3:0]       C_IC_MRMOVQ = 4'h5;
    localparam logic [3:0]       C_IC_POPQ   = 4'hB;
    localparam logic [3:0]       C_IC_JXX    = 4'h7;
    localparam logic [3:0]       C_IC_RET    = 4'h9;
    localparam logic [3:0]       C_REG_NONE  = 4'hF;
    localparam logic [1:0]       C_STAT_AOK  = 2'd0;
    localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       exc_q, exc_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0] lu_q, lu_d;
    logic [CNT_W-1:0] mp_q, mp_d;

    logic w_lu;
    logic w_mp;
    logic w_rt;
    logic w_exm;
    logic w_exw;
    logic w_cnt_en;
    logic w_retire;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    assign w_lu  = ((E_icode == C_IC_MRMOVQ) || (E_icode == C_IC_POPQ)) &&
                   (E_dstM != C_REG_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_mp  = (E_icode == C_IC_JXX) && !e_cnd;
    assign w_rt  = (D_icode == C_IC_RET) || (E_icode == C_IC_RET) ||
                   (M_icode == C_IC_RET);
    assign w_exm = (m_stat != C_STAT_AOK);
    assign w_exw = (W_stat != C_STAT_AOK);

    // ------------------------------------------------------------------------
    // Run/halt FSM: next state and stage controls
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        exc_d     = exc_q;
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        W_stall   = 1'b0;
        set_cc_en = 1'b0;

        if (rst) begin
            // Flush every stage register while reset is held.
            state_d  = ST_RUN;
            exc_d    = C_STAT_AOK;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    F_stall   = w_lu || w_rt;
                    D_stall   = w_lu;
                    D_bubble  = w_mp || (w_rt && !w_lu);
                    E_bubble  = w_mp || w_lu;
                    M_bubble  = w_exm || w_exw;
                    W_stall   = w_exw;
                    set_cc_en = !w_exm && !w_exw;
                    if (w_exw) begin
                        state_d = ST_HALT;
                        exc_d   = W_stat;
                    end
                end
                ST_HALT: begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    W_stall  = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Saturating performance counters (advance only in RUN, outside reset)
    // ------------------------------------------------------------------------
    assign w_cnt_en = !rst && (state_q == ST_RUN);
    assign w_retire = (W_icode != IC_NOP) && (W_stat == C_STAT_AOK) && !W_stall;

    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        lu_d  = lu_q;
        mp_d  = mp_q;
        if (w_cnt_en) begin
            if (cyc_q != C_CNT_MAX)             cyc_d = cyc_q + 1'b1;
            if (w_retire && (ret_q != C_CNT_MAX)) ret_d = ret_q + 1'b1;
            if (w_lu && (lu_q != C_CNT_MAX))      lu_d  = lu_q + 1'b1;
            if (w_mp && (mp_q != C_CNT_MAX))      mp_d  = mp_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            exc_q   <= C_STAT_AOK;
            cyc_q   <= '0;
            ret_q   <= '0;
            lu_q    <= '0;
            mp_q    <= '0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
            lu_q    <= lu_d;
            mp_q    <= mp_d;
        end
    end

    assign halted   = (state_q == ST_HALT);
    assign exc_code = exc_q;
    assign cyc_cnt  = cyc_q;
    assign ret_cnt  = ret_q;
    assign lu_cnt   = lu_q;
    assign mp_cnt   = mp_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Directed + randomized bench for pipe_ctrl_unit against a
//            rule-level reference model (two DUTs: CNT_W=32 and CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic        e_cnd;
    logic [1:0]  m_stat, W_stat;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted;
    logic [1:0]  exc_code;
    logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;

    logic        F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc_en4, halted4;
    logic [1:0]  exc_code4;
    logic [3:0]  cyc_cnt4, ret_cnt4, lu_cnt4, mp_cnt4;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.CNT_W(32), .IC_NOP(4'h1)) dut (
        .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc_en(set_cc_en), .halted(halted),
        .exc_code(exc_code), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt),
        .mp_cnt(mp_cnt)
    );

    pipe_ctrl_unit #(.CNT_W(4), .IC_NOP(4'h1)) dut4 (
        .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(F_stall4), .D_stall(D_stall4), .D_bubble(D_bubble4), .E_bubble(E_bubble4),
        .M_bubble(M_bubble4), .W_stall(W_stall4), .set_cc_en(set_cc_en4), .halted(halted4),
        .exc_code(exc_code4), .cyc_cnt(cyc_cnt4), .ret_cnt(ret_cnt4), .lu_cnt(lu_cnt4),
        .mp_cnt(mp_cnt4)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state
    bit         m_halt;
    logic [1:0] m_exc;
    longint     c_cyc, c_ret, c_lu, c_mp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // Expected {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en}
    function automatic logic [6:0] exp_ctrl();
        bit lu, mp, rt, exm, exw;
        if (rst)    return 7'b0011100;
        if (m_halt) return 7'b1101110;
        lu  = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
              (E_dstM == d_srcA || E_dstM == d_srcB);
        mp  = (E_icode == 4'h7) && (e_cnd == 1'b0);
        rt  = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        exm = (m_stat != 2'd0);
        exw = (W_stat != 2'd0);
        return {lu | rt, lu, mp | (rt & ~lu), mp | lu, exm | exw, exw, ~exm & ~exw};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_halt = 0; m_exc = 2'd0;
            c_cyc = 0; c_ret = 0; c_lu = 0; c_mp = 0;
        end else if (!m_halt) begin
            c_cyc++;
            if (W_icode != 4'h1 && W_stat == 2'd0) c_ret++;
            if ((E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
                (E_dstM == d_srcA || E_dstM == d_srcB)) c_lu++;
            if (E_icode == 4'h7 && !e_cnd) c_mp++;
            if (W_stat != 2'd0) begin
                m_halt = 1; m_exc = W_stat;
            end
        end
    endtask

    task automatic check_all();
        logic [6:0] e;
        e = exp_ctrl();
        chk("ctrl32", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en}, e);
        chk("ctrl4",  {F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc_en4}, e);
        chk("d_stall_bubble_excl", D_stall & D_bubble, 0);
        chk("halted",   halted, m_halt);
        chk("exc_code", exc_code, m_exc);
        chk("halted4",  halted4, m_halt);
        chk("cyc_cnt",  cyc_cnt, c_cyc[31:0]);
        chk("ret_cnt",  ret_cnt, c_ret[31:0]);
        chk("lu_cnt",   lu_cnt,  c_lu[31:0]);
        chk("mp_cnt",   mp_cnt,  c_mp[31:0]);
        chk("cyc_cnt4", cyc_cnt4, sat(c_cyc, 15));
        chk("ret_cnt4", ret_cnt4, sat(c_ret, 15));
        chk("lu_cnt4",  lu_cnt4,  sat(c_lu, 15));
        chk("mp_cnt4",  mp_cnt4,  sat(c_mp, 15));
    endtask

    // Apply inputs, check outputs mid-cycle, then advance one clock.
    task automatic step(input logic r, input logic [3:0] di, input logic [3:0] sa,
                        input logic [3:0] sb, input logic [3:0] ei, input logic [3:0] edm,
                        input logic cnd, input logic [3:0] mi, input logic [1:0] ms,
                        input logic [3:0] wi, input logic [1:0] ws);
        rst = r; D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_dstM = edm;
        e_cnd = cnd; M_icode = mi; m_stat = ms; W_icode = wi; W_stat = ws;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 2'd0, 4'h1, 2'd0);
    endtask

    function automatic logic [3:0] rnd_icode();
        logic [3:0] hot [5] = '{4'h5, 4'h7, 4'h9, 4'hB, 4'h1};
        if ($urandom_range(1, 0) == 1) return hot[$urandom_range(4, 0)];
        return 4'($urandom_range(11, 0));
    endfunction

    initial begin
        rst = 1'b1; D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1;
        E_dstM = 4'hF; e_cnd = 1'b0; M_icode = 4'h1; m_stat = 2'd0; W_icode = 4'h1;
        W_stat = 2'd0;
        m_halt = 0; m_exc = 2'd0; c_cyc = 0; c_ret = 0; c_lu = 0; c_mp = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset-held cycle, then load/use followed by a clean cycle
        step(1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 2'd0, 4'h1, 2'd0);
        step(1'b0, 4'h6, 4'h0, 4'h3, 4'h5, 4'h0, 1'b0, 4'h1, 2'd0, 4'h2, 2'd0);
        step(1'b0, 4'h6, 4'h0, 4'h3, 4'h1, 4'hF, 1'b0, 4'h1, 2'd0, 4'h2, 2'd0);
        // Mispredict
        step(1'b0, 4'h2, 4'h1, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 2'd0, 4'h6, 2'd0);
        // Ret walking D -> E -> M, then clear; ret in D with load/use in E
        step(1'b0, 4'h9, 4'h4, 4'h4, 4'h1, 4'hF, 1'b0, 4'h1, 2'd0, 4'h1, 2'd0);
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b0, 4'h1, 2'd0, 4'h1, 2'd0);
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h9, 2'd0, 4'h1, 2'd0);
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 2'd0, 4'h9, 2'd0);
        step(1'b0, 4'h9, 4'h4, 4'h2, 4'hB, 4'h4, 1'b1, 4'h1, 2'd0, 4'h1, 2'd0);
        // Address exception in M, then in W, then frozen HALT
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h5, 2'd2, 4'h3, 2'd0);
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 2'd0, 4'h5, 2'd2);
        for (int i = 0; i < 10; i++)
            step(1'b0, 4'h9, 4'h0, 4'h0, 4'h5, 4'h0, 1'b0, 4'h9, 2'd1, 4'h6, 2'd0);
        // Reset while halted, idle run, then saturation of the 4-bit counters
        step(1'b1, 4'h9, 4'h0, 4'h0, 4'h7, 4'h0, 1'b0, 4'h9, 2'd1, 4'h6, 2'd3);
        idle(5);
        idle(20);
        // HLT reaching W
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 2'd0, 4'h0, 2'd1);
        idle(2);

        // Randomized traffic with periodic reset out of HALT
        for (int i = 0; i < 600; i++) begin
            logic r;
            r = m_halt && ($urandom_range(3, 0) == 0);
            step(r, rnd_icode(), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                 rnd_icode(), ($urandom_range(3, 0) == 0) ? 4'hF : 4'($urandom_range(3, 0)),
                 1'($urandom_range(1, 0)), rnd_icode(),
                 ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0,
                 rnd_icode(),
                 ($urandom_range(39, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
